// File: rtl/rpsc_fault_latch.sv
// Five-channel fault latch: synchronize, debounce, latch until acknowledged.
// Tracks first-fault channel(s), trip count and refused acknowledges.
module rpsc_fault_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_not_fault,
  input  logic       i_ack,
  input  logic [4:0] i_mask,
  output logic       o_ff1,
  output logic       o_ff2,
  output logic       o_ff3,
  output logic       o_ff4,
  output logic       o_ff6,
  output logic       o_fault_any,
  output logic [4:0] o_first_fault,
  output logic [7:0] o_trip_count,
  output logic       o_clear_blocked
);

  localparam logic [7:0] DBC = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_DEB,
    S_LAT
  } ch_state_e;

  ch_state_e  state_q [5];
  ch_state_e  state_d [5];
  logic [7:0] cnt_q   [5];
  logic [7:0] cnt_d   [5];

  logic [4:0] sync1_q, sync2_q;
  logic [4:0] fault;
  logic       ack_q;
  logic       ack_rise;
  logic [4:0] ff_q, ff_d;
  logic [4:0] new_lat;
  logic       any_q, any_d;
  logic [4:0] first_q, first_d;
  logic [7:0] trip_q, trip_d;
  logic       blk_q, blk_d;

  assign fault    = ~sync2_q;
  assign ack_rise = i_ack & ~ack_q;

  // Per-channel debounce/latch next state plus derived status.
  always_comb begin
    new_lat = '0;
    ff_d    = '0;
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_CLEAR: begin
          cnt_d[i] = '0;
          if (fault[i] && !i_mask[i]) begin
            state_d[i] = S_DEB;
            cnt_d[i]   = 8'd1;
          end
        end
        S_DEB: begin
          if (i_mask[i]) begin
            state_d[i] = S_CLEAR;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DBC) begin
            state_d[i] = S_LAT;
            cnt_d[i]   = '0;
            new_lat[i] = 1'b1;
          end else if (fault[i]) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end else begin
            state_d[i] = S_CLEAR;
            cnt_d[i]   = '0;
          end
        end
        S_LAT: begin
          cnt_d[i] = '0;
          if (ack_rise && !fault[i]) begin
            state_d[i] = S_CLEAR;
          end
        end
        default: begin
          state_d[i] = S_CLEAR;
          cnt_d[i]   = '0;
        end
      endcase
      ff_d[i] = (state_d[i] == S_LAT);
    end
    any_d = |ff_d;
    blk_d = ack_rise & |(ff_q & fault);
    if (!any_d) begin
      first_d = '0;
    end else if (!any_q) begin
      first_d = new_lat;
    end else begin
      first_d = first_q;
    end
    trip_d = trip_q;
    if (|new_lat && trip_q != 8'hFF) begin
      trip_d = trip_q + 8'd1;
    end
  end

  // State, synchronizer and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= S_CLEAR;
        cnt_q[i]   <= '0;
      end
      sync1_q <= '1;
      sync2_q <= '1;
      ack_q   <= 1'b1;
      ff_q    <= '0;
      any_q   <= 1'b0;
      first_q <= '0;
      trip_q  <= '0;
      blk_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sync1_q <= i_not_fault;
      sync2_q <= sync1_q;
      ack_q   <= i_ack;
      ff_q    <= ff_d;
      any_q   <= any_d;
      first_q <= first_d;
      trip_q  <= trip_d;
      blk_q   <= blk_d;
    end
  end

  assign o_ff1           = ff_q[0];
  assign o_ff2           = ff_q[1];
  assign o_ff3           = ff_q[2];
  assign o_ff4           = ff_q[3];
  assign o_ff6           = ff_q[4];
  assign o_fault_any     = any_q;
  assign o_first_fault   = first_q;
  assign o_trip_count    = trip_q;
  assign o_clear_blocked = blk_q;

endmodule

// File: doc/rpsc_fault_latch.md
RPSC_FAULT_LATCH -- requirements
Module: rpsc_fault_latch

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, legal range 1..255: consecutive synchronized fault samples required to latch a channel.
REQ-002 clk  input  1  single clock for all state; rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_not_fault  input  5  raw active-low fault inputs, asynchronous to clk; bit0=FF1, bit1=FF2, bit2=FF3, bit3=FF4, bit4=FF6.
REQ-005 i_ack  input  1  operator fault-reset request, synchronous to clk; acted on at its rising edge only.
REQ-006 i_mask  input  5  synchronous maintenance bypass per channel, same bit map as i_not_fault; 1 = channel may not latch new faults.
REQ-007 o_ff1, o_ff2, o_ff3, o_ff4, o_ff6  output  1 each  latched fault flags, active-high; feed card-5 interlock inputs directly.
REQ-008 o_fault_any  output  1  OR of all five latched flags.
REQ-009 o_first_fault  output  5  one-hot (or multi-hot on ties) record of the channel(s) that latched first.
REQ-010 o_trip_count  output  8  saturating count of trip events since reset.
REQ-011 o_clear_blocked  output  1  one-cycle pulse: ack refused on at least one channel because its fault persists.

Function
REQ-012 Each i_not_fault bit SHALL pass through a 2-flop synchronizer; a synchronized fault is the inverse of the synchronized bit.
REQ-013 Each channel SHALL hold a debounce counter: increments on each cycle with a synchronized fault present and the channel unmasked; clears to 0 on any cycle with no synchronized fault or with the channel masked.
REQ-014 Channel states SHALL be CLEAR, DEBOUNCE, LATCHED: CLEAR->DEBOUNCE on first synchronized fault; DEBOUNCE->CLEAR when the fault drops or the channel is masked; DEBOUNCE->LATCHED when the counter has seen DEBOUNCE_CYCLES consecutive samples.
REQ-015 Latency: a latched flag SHALL rise exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the raw input low, held low throughout.
REQ-016 LATCHED SHALL be held regardless of input return or later mask assertion; exit is only via reset or REQ-017.
REQ-017 Ack edge: i_ack is registered; a rising edge (i_ack=1, previous=0) SHALL, at the next clock edge, clear every LATCHED channel whose synchronized fault is absent (->CLEAR, counter 0) and leave LATCHED every channel whose fault is present.
REQ-018 o_clear_blocked SHALL pulse high for exactly one cycle when an ack edge leaves one or more channels LATCHED due to persisting fault.
REQ-019 Simultaneous ack edge and debounce completion on the same channel: the channel SHALL end LATCHED (set wins).
REQ-020 i_ack held high SHALL produce only one clear action; no further action until it falls and rises again.
REQ-021 o_first_fault SHALL load the set of channels latching in a cycle where o_fault_any was 0; all channels latching that same cycle are recorded; it holds while o_fault_any=1 and returns to 0 in the cycle o_fault_any returns to 0.
REQ-022 o_trip_count SHALL increment by 1 in each cycle where at least one channel newly enters LATCHED, regardless of how many; saturates at 255; only reset clears it.
REQ-023 o_fault_any and all o_ff* SHALL be registered outputs, no combinational path from any input.

Reset
REQ-024 rst_n low SHALL immediately force all channels CLEAR, counters 0, synchronizer flops to 1 (no fault), all outputs 0.
REQ-025 The ack-history register SHALL reset to 1 so an i_ack held high across reset release causes no clear action.
REQ-026 Reset asserted mid-debounce or while LATCHED SHALL discard all state; after release a still-present fault SHALL re-latch with full REQ-015 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 i_not_fault[2] low from edge 0 -> o_ff3=1 at edge 6, o_fault_any=1, o_first_fault=5'b00100, o_trip_count=1.
REQ-028 i_not_fault[0] low for 3 cycles then high -> o_ff1 never asserts, o_trip_count unchanged.
REQ-029 FF4 latched, input still low, ack pulse -> o_ff4 stays 1, o_clear_blocked one-cycle 1; release input, ack again -> o_ff4=0, o_first_fault=0, o_clear_blocked=0.
REQ-030 i_not_fault[1] and [4] low on same edge -> o_ff2 and o_ff6 rise same cycle, o_first_fault=5'b10010, o_trip_count increments by 1.
REQ-031 i_mask[3]=1 with i_not_fault[3] low 10 cycles -> o_ff4=0; FF1 latched then mask[0] set -> o_ff1 stays 1.
REQ-032 rst_n pulsed low while FF3 latched and i_ack held high -> all outputs 0 immediately; after release no ack action, FF3 re-latches 6 edges later if input still low; 300 trips -> o_trip_count=255.
